// File: rtl/sub_cmd_initiator_pkg.sv
// Shared definitions for the cmd/rsp initiator: op codes, FSM states and command-word helper.
package sub_cmd_initiator_pkg;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Evaluated at 32 bits; the caller truncates, which yields modulo-2^WIDTH wrap.
  function automatic logic [31:0] cmd_word(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      default: res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sub_cmd_timer.sv
// Clearable wait counter with terminal-count flag at TIMEOUT-1.
module sub_cmd_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [CW-1:0] r_cnt;

  assign o_tc_c = (r_cnt == CW'(TIMEOUT - 1));

  // Holds at terminal count so an enabled counter can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc_c) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sub_cmd_initiator.sv
// Initiator for the doubling responder: builds a command from operands, issues it,
// waits for the response with timeout, and returns result/timeout/self-check flags.
module sub_cmd_initiator
  import sub_cmd_initiator_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WIDTH-1:0] cmd_payload,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_timeout,
  output logic             out_mismatch,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           r_state;
  logic             r_cmd_valid;
  logic [WIDTH-1:0] r_cmd_payload;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_timeout;
  logic             r_out_mismatch;
  logic [CNT_W-1:0] r_done_cnt;

  logic             w_req_hs;
  logic             w_cmd_hs;
  logic             w_out_hs;
  logic             w_tmr_tc;
  logic [WIDTH-1:0] w_cmd_word;
  logic [WIDTH-1:0] w_rsp_expect;

  assign req_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign cmd_valid    = r_cmd_valid;
  assign cmd_payload  = r_cmd_payload;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_timeout  = r_out_timeout;
  assign out_mismatch = r_out_mismatch;
  assign done_cnt     = r_done_cnt;

  assign w_req_hs     = req_valid && (r_state == IDLE);
  assign w_cmd_hs     = r_cmd_valid && cmd_ready;
  assign w_out_hs     = r_out_valid && out_ready;
  assign w_cmd_word   = WIDTH'(cmd_word(req_op, 32'(req_a), 32'(req_b)));
  assign w_rsp_expect = WIDTH'(r_cmd_payload + r_cmd_payload);

  sub_cmd_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (TMR_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cmd_hs),
    .i_en   (r_state == WAIT_RSP),
    .o_tc_c (w_tmr_tc)
  );

  // Transaction FSM with registered command and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cmd_valid    <= 1'b0;
      r_cmd_payload  <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_timeout  <= 1'b0;
      r_out_mismatch <= 1'b0;
      r_done_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_hs) begin
            r_cmd_payload <= w_cmd_word;
            r_cmd_valid   <= 1'b1;
            r_state       <= SEND;
          end
        end
        SEND: begin
          if (w_cmd_hs) begin
            r_cmd_valid <= 1'b0;
            r_state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response in the terminal-count cycle takes priority over the timeout.
          if (rsp_valid) begin
            r_out_data     <= rsp_payload;
            r_out_timeout  <= 1'b0;
            r_out_mismatch <= (rsp_payload != w_rsp_expect);
            r_out_valid    <= 1'b1;
            r_state        <= DONE;
          end else if (w_tmr_tc) begin
            r_out_data     <= '0;
            r_out_timeout  <= 1'b1;
            r_out_mismatch <= 1'b0;
            r_out_valid    <= 1'b1;
            r_state        <= DONE;
          end
        end
        DONE: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_cmd_initiator.sv
// Directed self-checking bench for sub_cmd_initiator with hand-computed expectations.
module tb_sub_cmd_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_op;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_payload;
  logic       rsp_valid;
  logic [3:0] rsp_payload;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_timeout;
  logic       out_mismatch;
  logic       busy;
  logic [7:0] done_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_cmd_initiator #(.WIDTH(4), .TIMEOUT(15), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_payload  (cmd_payload),
    .rsp_valid    (rsp_valid),
    .rsp_payload  (rsp_payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_timeout  (out_timeout),
    .out_mismatch (out_mismatch),
    .busy         (busy),
    .done_cnt     (done_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Full transaction against a zero-latency ideal responder.
  task automatic do_ideal(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] ecmd, input logic [3:0] eout, input logic [7:0] ecnt);
    start_req(op, a, b);
    check("cmd_valid_c1", 32'(cmd_valid), 32'd1);
    check("cmd_payload", 32'(cmd_payload), 32'(ecmd));
    tick();
    check("cmd_valid_clr", 32'(cmd_valid), 32'd0);
    rsp_valid   = 1'b1;
    rsp_payload = eout;
    tick();
    rsp_valid = 1'b0;
    check("out_valid_c3", 32'(out_valid), 32'd1);
    check("out_data", 32'(out_data), 32'(eout));
    check("out_timeout", 32'(out_timeout), 32'd0);
    check("out_mismatch", 32'(out_mismatch), 32'd0);
    check("req_ready_done", 32'(req_ready), 32'd0);
    tick();
    check("out_valid_clr", 32'(out_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("done_cnt", 32'(done_cnt), 32'(ecnt));
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    req_op      = '0;
    cmd_ready   = 1'b1;
    rsp_valid   = 1'b0;
    rsp_payload = '0;
    out_ready   = 1'b1;
    #12;
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_payload", 32'(cmd_payload), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_timeout", 32'(out_timeout), 32'd0);
    check("rst_out_mismatch", 32'(out_mismatch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    // Arithmetic through an ideal responder.
    do_ideal(2'd0, 4'd3, 4'd2, 4'h5, 4'hA, 8'd1);
    do_ideal(2'd1, 4'd2, 4'd5, 4'hD, 4'hA, 8'd2);
    do_ideal(2'd0, 4'd9, 4'd9, 4'h2, 4'h4, 8'd3);
    do_ideal(2'd2, 4'hC, 4'hA, 4'h8, 4'h0, 8'd4);
    do_ideal(2'd3, 4'h7, 4'hF, 4'h7, 4'hE, 8'd5);

    // Command backpressure, then result backpressure.
    cmd_ready = 1'b0;
    out_ready = 1'b0;
    start_req(2'd0, 4'd1, 4'd1);
    for (int i = 0; i < 6; i++) begin
      check("bp_cmd_valid", 32'(cmd_valid), 32'd1);
      check("bp_cmd_payload", 32'(cmd_payload), 32'd2);
      check("bp_no_out", 32'(out_valid), 32'd0);
      tick();
    end
    cmd_ready   = 1'b1;
    rsp_valid   = 1'b1;
    rsp_payload = 4'hF;
    check("bp_cmd_valid_hs", 32'(cmd_valid), 32'd1);
    tick();
    rsp_valid = 1'b0;
    check("hs_rsp_ignored", 32'(out_valid), 32'd0);
    rsp_valid   = 1'b1;
    rsp_payload = 4'd4;
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'd4);
      check("bp_out_timeout", 32'(out_timeout), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_done_cnt", 32'(done_cnt), 32'd6);
    check("bp_req_ready_after", 32'(req_ready), 32'd1);

    // Silent responder: timeout after exactly 15 WAIT_RSP cycles.
    out_ready = 1'b0;
    start_req(2'd0, 4'd5, 4'd0);
    tick();
    for (int i = 0; i < 15; i++) begin
      check("to_waiting", 32'(out_valid), 32'd0);
      tick();
    end
    check("to_out_valid", 32'(out_valid), 32'd1);
    check("to_out_timeout", 32'(out_timeout), 32'd1);
    check("to_out_data", 32'(out_data), 32'd0);
    check("to_out_mismatch", 32'(out_mismatch), 32'd0);
    rsp_valid   = 1'b1;
    rsp_payload = 4'h7;
    tick();
    rsp_valid = 1'b0;
    check("late_rsp_data", 32'(out_data), 32'd0);
    check("late_rsp_timeout", 32'(out_timeout), 32'd1);
    out_ready = 1'b1;
    tick();
    check("to_done_cnt", 32'(done_cnt), 32'd7);
    rsp_valid   = 1'b1;
    rsp_payload = 4'h9;
    tick();
    rsp_valid = 1'b0;
    check("idle_rsp_busy", 32'(busy), 32'd0);
    check("idle_rsp_out_valid", 32'(out_valid), 32'd0);

    // Response in the terminal-count cycle beats the timeout.
    start_req(2'd0, 4'd5, 4'd0);
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("race_pre", 32'(out_valid), 32'd0);
    rsp_valid   = 1'b1;
    rsp_payload = 4'hA;
    tick();
    rsp_valid = 1'b0;
    check("race_out_valid", 32'(out_valid), 32'd1);
    check("race_out_timeout", 32'(out_timeout), 32'd0);
    check("race_out_data", 32'(out_data), 32'hA);
    tick();
    check("race_done_cnt", 32'(done_cnt), 32'd8);

    // Corrupt responder.
    start_req(2'd0, 4'd3, 4'd2);
    tick();
    rsp_valid   = 1'b1;
    rsp_payload = 4'd3;
    tick();
    rsp_valid = 1'b0;
    check("bad_out_data", 32'(out_data), 32'd3);
    check("bad_out_mismatch", 32'(out_mismatch), 32'd1);
    tick();
    check("bad_done_cnt", 32'(done_cnt), 32'd9);

    // Asynchronous reset while waiting for a response.
    start_req(2'd0, 4'd3, 4'd2);
    tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    do_ideal(2'd0, 4'd3, 4'd2, 4'h5, 4'hA, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
